// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences and supervises a CPU core for simulation and board bring-up.
// It holds the CPU in reset for a fixed number of cycles when a run starts,
// lets it run while counting cycles and retired instructions, and freezes
// it on ECALL/EBREAK (halt) or when the cycle budget is exhausted (timeout).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset (highest priority)
//   run_en       level request: 1 starts/keeps a run, 0 aborts/acknowledges
//   inst         instruction word retiring this cycle
//   inst_valid   inst is valid and retires this cycle
//   cpu_rst      synchronous active-high reset to the CPU
//   cpu_clk_en   CPU clock enable, 0 freezes CPU state
//   running      run phase active
//   halted       program ended via ECALL/EBREAK (sticky until run_en drops)
//   timed_out    cycle budget exhausted (sticky until run_en drops)
//   cycle_count  cycles spent in the run phase
//   inst_count   instructions retired in the run phase
//
// Every output is a flop; nothing goes combinationally from an input to an
// output.

module cpu_run_controller #(
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    output logic             cpu_rst,
    output logic             cpu_clk_en,
    output logic             running,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count
);

    // Hold counter only has to reach RESET_CYCLES-1.
    localparam int                 HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam bit                 TOUT_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]   TOUT_LAST  = TOUT_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [31:0]        INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0]        INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_TOUT = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    logic               cpu_rst_q, cpu_clk_en_q, running_q, halted_q, timed_out_q;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Exact 32-bit match: other SYSTEM encodings (CSR ops, MRET...) never halt.
    function automatic logic is_halt_inst(input logic [31:0] w);
        is_halt_inst = (w == INST_ECALL) || (w == INST_EBREAK);
    endfunction

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cycle_d  = cycle_q;
        icount_d = icount_q;
        case (state_q)
            S_IDLE: begin
                if (run_en) begin
                    state_d  = S_HOLD;
                    hold_d   = {HOLD_W{1'b0}};
                    cycle_d  = {CNT_W{1'b0}};
                    icount_d = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!run_en) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            S_RUN: begin
                // Abort keeps the counters as they were for inspection.
                if (!run_en) begin
                    state_d = S_IDLE;
                end else begin
                    cycle_d = sat_inc(cycle_q);
                    if (inst_valid) begin
                        icount_d = sat_inc(icount_q);
                    end else begin
                        icount_d = icount_q;
                    end
                    // Halt outranks timeout when both land on the same cycle.
                    if (inst_valid && is_halt_inst(inst)) begin
                        state_d = S_HALT;
                    end else if (TOUT_EN && (cycle_q == TOUT_LAST)) begin
                        state_d = S_TOUT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_HALT, S_TOUT: begin
                // Only a dropped run_en leaves; holding it high never restarts.
                if (!run_en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and output flops; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= {HOLD_W{1'b0}};
            cycle_q      <= {CNT_W{1'b0}};
            icount_q     <= {CNT_W{1'b0}};
            cpu_rst_q    <= 1'b1;
            cpu_clk_en_q <= 1'b1;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            icount_q     <= icount_d;
            cpu_rst_q    <= (state_d == S_IDLE) || (state_d == S_HOLD);
            cpu_clk_en_q <= (state_d != S_HALT) && (state_d != S_TOUT);
            running_q    <= (state_d == S_RUN);
            halted_q     <= (state_d == S_HALT);
            timed_out_q  <= (state_d == S_TOUT);
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign cpu_clk_en  = cpu_clk_en_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_q;
    assign inst_count  = icount_q;

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences and supervises the CPU core for simulation and board bring-up.
- Drives the CPU's synchronous reset and clock enable.
- Monitors the retiring instruction stream, detects program end (ECALL/EBREAK) or cycle-budget timeout, and exposes cycle and instruction counters.
- Sits between the top-level clk/rst and the CPU instance, so benches and the FPGA top need no hand-timed reset pulses.

Parameters:
- RESET_CYCLES, 4: cycles cpu_rst is held high after a run starts; legal values are 1 or more.
- TIMEOUT, 1000: cycle budget in RUN; 0 disables the timeout.
- CNT_W, 32: width of the cycle and instruction counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run_en  input  1  level; 1 requests a run, 0 aborts or acknowledges.
- inst  input  32  instruction word retiring this cycle.
- inst_valid  input  1  inst is valid and retires this cycle.
- cpu_rst  output  1  synchronous active-high reset to the CPU.
- cpu_clk_en  output  1  CPU clock enable; 0 freezes CPU state.
- running  output  1  state is RUN.
- halted  output  1  program ended via ECALL/EBREAK (sticky).
- timed_out  output  1  cycle budget exhausted (sticky).
- cycle_count  output  CNT_W  cycles spent in RUN.
- inst_count  output  CNT_W  instructions retired in RUN.

Behaviour:
- States: IDLE, HOLD, RUN, HALT, TOUT. All outputs are decoded from registers only; there are no combinational input-to-output paths.
- Reset (rst=1 at an edge, highest priority, including mid-run):
  - state goes to IDLE; both counters clear.
  - cpu_rst=1, cpu_clk_en=1, running=0, halted=0, timed_out=0.
- IDLE:
  - cpu_rst=1, cpu_clk_en=1.
  - run_en=1 sampled → HOLD; the hold counter loads 0 and both counters clear.
- HOLD:
  - cpu_rst=1, cpu_clk_en=1; the hold counter increments each cycle.
  - When hold counter = RESET_CYCLES-1 → RUN. cpu_rst is therefore high for exactly RESET_CYCLES cycles in HOLD.
  - run_en=0 → IDLE (abort).
- RUN:
  - cpu_rst=0, cpu_clk_en=1, running=1.
  - cycle_count increments every cycle; inst_count increments when inst_valid=1.
  - inst_valid=1 and (inst=32'h00000073 ECALL or inst=32'h00100073 EBREAK) → HALT. The halting instruction is counted.
  - TIMEOUT≠0 and cycle_count=TIMEOUT-1 → TOUT. cycle_count then reads TIMEOUT.
  - Halt and timeout in the same cycle → HALT wins; timed_out stays 0.
  - run_en=0 → IDLE. Counters are retained until the next run start.
  - Precedence: rst > run_en=0 abort > HALT > TOUT.
  - With TIMEOUT=0, both counters saturate at all-ones; there is no wrap.
- HALT / TOUT:
  - cpu_rst=0, cpu_clk_en=0, so CPU architectural state is frozen for inspection.
  - halted=1 (HALT) or timed_out=1 (TOUT), sticky; counters frozen.
  - Only leave on run_en=0 → IDLE, which clears the flags.
  - run_en held at 1 never auto-restarts a run.
- Instruction matching is an exact 32-bit compare. Other SYSTEM encodings (e.g. CSR ops) do not halt.
- inst and inst_valid are ignored outside RUN.

Test Plan:
- Reset, then run_en=1 at cycle 2 (RESET_CYCLES=4):
  - cpu_rst high through cycle 6 (4 HOLD cycles) and low from cycle 7.
  - running=1 from cycle 7; cycle_count=1 one cycle later.
- RUN with inst_valid=1 for 10 cycles of NOPs (32'h00000013), then ECALL:
  - inst_count=11; halted=1 the next cycle; cpu_clk_en=0.
  - Both counters stay constant for 20 further cycles.
- TIMEOUT=8, inst_valid=0 throughout:
  - timed_out=1 after 8 RUN cycles; cycle_count=8; inst_count=0; halted=0.
- TIMEOUT=8, EBREAK presented on the 8th RUN cycle (cycle_count=7):
  - halted=1 and timed_out=0; inst_count=1.
- Abort and restart:
  - run_en→0 mid-HOLD returns to IDLE with cpu_rst=1.
  - rst=1 mid-RUN with cycle_count=5: the next cycle shows IDLE, counters=0, cpu_rst=1.
  - run_en held 1 in HALT: no restart. Dropping run_en clears halted; re-raising it starts a new HOLD with counters at 0.
- Non-halting SYSTEM instruction:
  - inst=32'h30200073 (MRET) with inst_valid=1 → stays in RUN; inst_count increments.
